spram_rr_arbiter: RTL and testbench
===================================

Name: spram_rr_arbiter

Overview:
- Shares one single-port RAM (DEPTH = 2**ADD_WIDTH words of DATA_WIDTH bits, embedded in this block) between two requesters, A and B.
- Requesters use a req/gnt handshake and receive tagged read responses one cycle after grant.
- Arbitration is round-robin with one access per clock, so each requester waits at most one cycle under contention.
- The block sits between two bus masters (e.g. a DMA path and a CPU path) and the shared scratch RAM.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADD_WIDTH, 4, address width; RAM depth = 2**ADD_WIDTH.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A access request; held until a_gnt.
- a_we  in  1  A: 1 = write, 0 = read; stable while a_req=1.
- a_addr  in  ADD_WIDTH  A word address; stable while a_req=1.
- a_wdata  in  DATA_WIDTH  A write data; stable while a_req=1.
- a_gnt  out  1  A access accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rdata  out  DATA_WIDTH  A read data (registered).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to the A ports, for requester B.

Behaviour:
- State:
  - prio register: 0 = A favoured, 1 = B favoured.
  - Per-side rvalid/rdata registers.
  - Memory array.
- Reset (async, reset=1):
  - prio=0.
  - a_rvalid=b_rvalid=0.
  - a_rdata=b_rdata=0.
  - a_gnt=b_gnt=0 while reset is held.
  - Memory contents are not cleared; any in-flight read response is discarded.
- Grant logic (combinational from req and prio):
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both requesting: the favoured side is granted.
  - Neither requesting: no grant.
  - a_gnt and b_gnt are never both 1.
- prio update at posedge:
  - If A granted, prio<=1.
  - If B granted, prio<=0.
  - If no grant, prio holds.
  - Consequence: a sole requester issuing back-to-back requests gets a grant every cycle; under contention, grants alternate A,B,A,B.
- Granted write: mem[addr]<=wdata at the edge ending the grant cycle. No read response is produced.
- Granted read:
  - x_rdata<=mem[addr] (old contents) and x_rvalid<=1 at the edge ending the grant cycle.
  - Read latency is exactly 1 cycle from gnt.
- x_rvalid is a one-cycle pulse per granted read. It deasserts the next cycle unless another read for the same side is granted. x_rdata holds its last value when rvalid=0.
- Ordering:
  - A write granted in cycle N is visible to any read granted in cycle N+1 or later, from either side.
  - Each side's accesses complete in request order.
- Address wrap: not applicable; addresses are always in range (full ADD_WIDTH decode).
- Protocol rule: a requester must not change we/addr/wdata or drop req before gnt. Behaviour if this rule is violated is undefined, but the block must not grant both sides.
- Reset mid-operation: a pending req is simply re-arbitrated after reset deasserts, with prio=0.

Test Plan:
1. Reset, then A writes 0x5A to addr 3 (single cycle, a_gnt=1), then A reads addr 3 -> a_gnt=1 in the read cycle; next cycle a_rvalid=1, a_rdata=0x5A; b_rvalid stays 0.
2. A and B both request reads every cycle for 6 cycles, starting at prio=0 -> grants A,B,A,B,A,B; each rvalid pulses the cycle after its own grant with data from its own address.
3. B alone issues reads of addr 0..15 on consecutive cycles (after writes of value=addr) -> b_gnt=1 every cycle; b_rdata sequence 0x00..0x0F, one per cycle, 1-cycle latency.
4. Same-address hazard: B writes 0xC3 to addr 7 (cycle N) while A requests a read of addr 7 -> A is granted in N+1 and returns 0xC3 (write-before-read order holds).
5. Reset mid-operation: assert reset during the cycle after an A read grant -> a_rvalid=0, a_rdata=0 immediately; prio=0 after release; memory retains all earlier writes (verify by readback).
6. Idle cycles: no requests for 3 cycles between contended pairs -> no grants, no rvalid, prio unchanged; the next contention resolves per the held prio.

Source files
------------

// File: rtl/spram_rr_arbiter.sv
// rtl/spram_rr_arbiter.sv - two-requester round-robin arbiter in front of an embedded single-port RAM
// One access per clock; read data returns on the requester's own tagged rvalid/rdata one cycle after grant.
module spram_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADD_WIDTH-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADD_WIDTH-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADD_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  prio;

  logic                  acc_en;
  logic                  acc_we;
  logic [ADD_WIDTH-1:0]  acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  // Grants are mutually exclusive by construction and forced low while reset is held.
  always_comb begin
    a_gnt = ~reset & a_req & (~b_req | ~prio);
    b_gnt = ~reset & b_req & (~a_req |  prio);
  end

  always_comb begin
    acc_en    = a_gnt | b_gnt;
    acc_we    = b_gnt ? b_we    : a_we;
    acc_addr  = b_gnt ? b_addr  : a_addr;
    acc_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // Memory contents survive reset, so the array lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (a_gnt) begin
      prio <= 1'b1;
    end else if (b_gnt) begin
      prio <= 1'b0;
    end
  end

  // Reads sample the pre-write contents; rdata holds its value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      if (a_gnt && !a_we) begin
        a_rdata <= mem[a_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= b_gnt & ~b_we;
      if (b_gnt && !b_we) begin
        b_rdata <= mem[b_addr];
      end
    end
  end

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb/tb_spram_rr_arbiter.sv - bench for spram_rr_arbiter
// Constant vector table plus hand sequences and random traffic against a served-last reference model.
module tb_spram_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  spram_rr_arbiter #(.DATA_WIDTH(8), .ADD_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  typedef struct {
    logic       areq, awe;
    logic [3:0] aaddr;
    logic [7:0] awd;
    logic       breq, bwe;
    logic [3:0] baddr;
    logic [7:0] bwd;
    logic       eag, ebg, earv;
    logic [7:0] eard;
    logic       ebrv;
    logic [7:0] ebrd;
  } vec_t;

  vec_t vt [$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: memory image, which side was served most recently, and response registers.
  logic [7:0] m_mem [16];
  bit         m_served_a;
  logic       m_arv, m_brv, e_ag, e_bg;
  logic [7:0] m_ard, m_brd;

  logic       s_ag, s_bg, s_arv, s_brv;
  logic [7:0] s_ard, s_brd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int areq, awe, aaddr, awd, breq, bwe, baddr, bwd,
                         input int eag, ebg, earv, eard, ebrv, ebrd);
    vec_t v;
    v.areq = 1'(areq); v.awe = 1'(awe); v.aaddr = 4'(aaddr); v.awd = 8'(awd);
    v.breq = 1'(breq); v.bwe = 1'(bwe); v.baddr = 4'(baddr); v.bwd = 8'(bwd);
    v.eag = 1'(eag); v.ebg = 1'(ebg); v.earv = 1'(earv); v.eard = 8'(eard);
    v.ebrv = 1'(ebrv); v.ebrd = 8'(ebrd);
    vt.push_back(v);
  endtask

  task automatic model_reset();
    m_served_a = 1'b0;
    m_arv = 1'b0; m_ard = 8'h00;
    m_brv = 1'b0; m_brd = 8'h00;
  endtask

  task automatic model_step();
    bit a_turn;
    a_turn = !m_served_a;
    e_ag = a_req && (!b_req || a_turn);
    e_bg = b_req && !e_ag;
    m_arv = e_ag && !a_we;
    m_brv = e_bg && !b_we;
    if (m_arv) m_ard = m_mem[a_addr];
    if (m_brv) m_brd = m_mem[b_addr];
    if (e_ag && a_we) m_mem[a_addr] = a_wdata;
    if (e_bg && b_we) m_mem[b_addr] = b_wdata;
    if (e_ag) m_served_a = 1'b1;
    if (e_bg) m_served_a = 1'b0;
  endtask

  // Called at posedge+1; drives one cycle, samples grants mid-cycle and responses after the edge.
  task automatic step(input logic ar, aw, input logic [3:0] aa, input logic [7:0] ad,
                      input logic br, bw, input logic [3:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #3;
    s_ag = a_gnt; s_bg = b_gnt;
    model_step();
    @(posedge clk);
    #1;
    s_arv = a_rvalid; s_ard = a_rdata; s_brv = b_rvalid; s_brd = b_rdata;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " a_gnt"}, s_ag, e_ag);
    chk({tag, " b_gnt"}, s_bg, e_bg);
    chk({tag, " a_rvalid"}, s_arv, m_arv);
    chk({tag, " a_rdata"}, s_ard, m_ard);
    chk({tag, " b_rvalid"}, s_brv, m_brv);
    chk({tag, " b_rdata"}, s_brd, m_brd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       pa, pb, raw, rbw;
    logic [3:0] raa, rba;
    logic [7:0] rad, rbd;

    // Expected values below are hand-derived from the arbitration rules.
    add_vec(1,1,3,'h5A, 0,0,0,0,    1,0, 0,'h00, 0,'h00);
    add_vec(1,0,3,0,    0,0,0,0,    1,0, 1,'h5A, 0,'h00);
    add_vec(0,0,0,0,    0,0,0,0,    0,0, 0,'h5A, 0,'h00);
    add_vec(0,0,0,0,    1,1,5,'h33, 0,1, 0,'h5A, 0,'h00);
    add_vec(1,0,3,0,    1,0,5,0,    1,0, 1,'h5A, 0,'h00);
    add_vec(1,0,3,0,    1,0,5,0,    0,1, 0,'h5A, 1,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    1,0, 1,'h5A, 0,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    0,1, 0,'h5A, 1,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    1,0, 1,'h5A, 0,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    0,1, 0,'h5A, 1,'h33);
    add_vec(1,1,7,'h11, 0,0,0,0,    1,0, 0,'h5A, 0,'h33);
    add_vec(1,0,7,0,    1,1,7,'hC3, 0,1, 0,'h5A, 0,'h33);
    add_vec(1,0,7,0,    0,0,0,0,    1,0, 1,'hC3, 0,'h33);
    add_vec(0,0,0,0,    0,0,0,0,    0,0, 0,'hC3, 0,'h33);
    add_vec(0,0,0,0,    0,0,0,0,    0,0, 0,'hC3, 0,'h33);
    add_vec(0,0,0,0,    0,0,0,0,    0,0, 0,'hC3, 0,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    0,1, 0,'hC3, 1,'h33);
    add_vec(1,0,3,0,    1,0,5,0,    1,0, 1,'h5A, 0,'h33);

    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd0; b_wdata = 8'h00;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_gnt", a_gnt, 1'b0);
    chk("reset b_gnt", b_gnt, 1'b0);
    chk("reset a_rvalid", a_rvalid, 1'b0);
    chk("reset b_rvalid", b_rvalid, 1'b0);
    chk("reset a_rdata", a_rdata, 8'h00);
    chk("reset b_rdata", b_rdata, 8'h00);
    reset = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].areq, vt[i].awe, vt[i].aaddr, vt[i].awd,
           vt[i].breq, vt[i].bwe, vt[i].baddr, vt[i].bwd);
      chk($sformatf("vec%0d a_gnt", i), s_ag, vt[i].eag);
      chk($sformatf("vec%0d b_gnt", i), s_bg, vt[i].ebg);
      chk($sformatf("vec%0d a_rvalid", i), s_arv, vt[i].earv);
      chk($sformatf("vec%0d a_rdata", i), s_ard, vt[i].eard);
      chk($sformatf("vec%0d b_rvalid", i), s_brv, vt[i].ebrv);
      chk($sformatf("vec%0d b_rdata", i), s_brd, vt[i].ebrd);
    end

    // Reset in the cycle after an A read grant, with a new A request pending.
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("midrst pre a_rvalid", s_arv, 1'b1);
    chk("midrst pre a_rdata", s_ard, 8'h5A);
    a_req = 1'b1; a_addr = 4'd5; b_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst a_rvalid", a_rvalid, 1'b0);
    chk("midrst a_rdata", a_rdata, 8'h00);
    chk("midrst a_gnt", a_gnt, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    chk("postrst a_gnt", s_ag, 1'b1);
    chk("postrst b_gnt", s_bg, 1'b0);
    chk("postrst a_rdata", s_ard, 8'h33);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    chk("postrst2 b_gnt", s_bg, 1'b1);
    chk("postrst2 b_rdata", s_brd, 8'hC3);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("postrst3 a_rdata", s_ard, 8'h5A);

    // B alone: fill then stream reads back-to-back.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'(i), 8'(i));
      chk($sformatf("bfill%0d b_gnt", i), s_bg, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'(i), 8'h00);
      chk($sformatf("bread%0d b_gnt", i), s_bg, 1'b1);
      chk($sformatf("bread%0d b_rvalid", i), s_brv, 1'b1);
      chk($sformatf("bread%0d b_rdata", i), s_brd, 8'(i));
      chk($sformatf("bread%0d a_rvalid", i), s_arv, 1'b0);
    end

    // Random traffic; each side holds its request fields until granted.
    pa = 1'b0; pb = 1'b0;
    raw = 1'b0; raa = 4'd0; rad = 8'h00; rbw = 1'b0; rba = 4'd0; rbd = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1'b1; raw = 1'($urandom); raa = 4'($urandom); rad = 8'($urandom);
      end
      if (!pb && ($urandom_range(0, 3) != 0)) begin
        pb = 1'b1; rbw = 1'($urandom); rba = 4'($urandom); rbd = 8'($urandom);
      end
      step(pa, raw, raa, rad, pb, rbw, rba, rbd);
      chk_model($sformatf("rnd%0d", c));
      if (s_ag) pa = 1'b0;
      if (s_bg) pb = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
